// File: rtl/sys_arr_pkg.sv
// Shared systolic-array parameters and the types used by the row feeder.
package sys_arr_pkg;

    localparam int N        = 4;
    localparam int DW       = 16;
    localparam int FEED_GAP = 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DRAIN = 3'd1,
        ST_LOAD_W     = 3'd2,
        ST_WAIT_SPACE = 3'd3,
        ST_LOAD_IN    = 3'd4,
        ST_GAP_WAIT   = 3'd5,
        ST_DONE       = 3'd6
    } feed_state_e;

    typedef enum logic {
        ROW_WEIGHT = 1'b0,
        ROW_INPUT  = 1'b1
    } row_type_e;

endpackage

// File: rtl/systolic_array_row_feeder.sv
// Tile sequencer for the systolic array: weight rows high-to-low, then input and
// partial-sum rows low-to-high with an idle gap between input issues.
module systolic_array_row_feeder #(
    parameter int N   = sys_arr_pkg::N,
    parameter int DW  = sys_arr_pkg::DW,
    parameter int GAP = sys_arr_pkg::FEED_GAP
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_load_weights,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [N*DW-1:0]        row_data,
    input  logic [N*DW-1:0]        row_partial,
    input  logic                   drained,
    input  logic                   fifo_has_space,
    output logic                   weight_en,
    output logic                   input_en,
    output logic                   partial_en,
    output logic [$clog2(N)-1:0]   row_in_en,
    output logic [$clog2(N)-1:0]   row_ps_en,
    output logic [N*DW-1:0]        array_in,
    output logic [N*DW-1:0]        array_in_partials,
    output logic                   busy,
    output logic                   tile_done
);
    import sys_arr_pkg::*;

    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [1:0]    GAP_LAST = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

    feed_state_e state;
    feed_state_e next_state;
    logic [CW-1:0] cnt;
    logic [1:0]    gap_cnt;
    logic          accept;
    logic          cmd_take;
    row_type_e     row_type;

    // Both handshakes are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid may wait on ready indefinitely.
    assign row_ready = (state == ST_LOAD_W) || (state == ST_LOAD_IN);
    assign busy      = (state != ST_IDLE);
    assign accept    = row_valid && row_ready;
    assign cmd_take  = cmd_valid && cmd_ready;
    assign row_type  = (state == ST_LOAD_W) ? ROW_WEIGHT : ROW_INPUT;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (cmd_take) next_state = cmd_load_weights ? ST_WAIT_DRAIN : ST_WAIT_SPACE;
            ST_WAIT_DRAIN: if (drained) next_state = ST_LOAD_W;
            ST_LOAD_W:     if (accept && cnt == LAST_CNT) next_state = ST_WAIT_SPACE;
            ST_WAIT_SPACE: if (fifo_has_space) next_state = ST_LOAD_IN;
            ST_LOAD_IN: begin
                if (accept) begin
                    if (cnt == LAST_CNT)  next_state = ST_DONE;
                    else if (GAP > 0)     next_state = ST_GAP_WAIT;
                end
            end
            ST_GAP_WAIT:   if (gap_cnt == GAP_LAST) next_state = ST_LOAD_IN;
            ST_DONE:       next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            gap_cnt           <= '0;
            cmd_ready         <= 1'b0;
            tile_done         <= 1'b0;
            weight_en         <= 1'b0;
            input_en          <= 1'b0;
            partial_en        <= 1'b0;
            row_in_en         <= '0;
            row_ps_en         <= '0;
            array_in          <= '0;
            array_in_partials <= '0;
        end else begin
            state     <= next_state;
            // Registered so it stays low through reset and rises one edge after release.
            cmd_ready <= (next_state == ST_IDLE);
            tile_done <= (state == ST_DONE);
            gap_cnt   <= (state == ST_GAP_WAIT) ? gap_cnt + 2'd1 : 2'd0;

            if ((state == ST_WAIT_DRAIN && next_state == ST_LOAD_W) ||
                (state == ST_WAIT_SPACE && next_state == ST_LOAD_IN))
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;

            weight_en         <= 1'b0;
            input_en          <= 1'b0;
            partial_en        <= 1'b0;
            row_in_en         <= '0;
            row_ps_en         <= '0;
            array_in          <= '0;
            array_in_partials <= '0;
            if (accept) begin
                array_in <= row_data;
                case (row_type)
                    ROW_WEIGHT: begin
                        weight_en <= 1'b1;
                        row_in_en <= LAST_IDX - cnt[IW-1:0];
                    end
                    default: begin
                        input_en          <= 1'b1;
                        partial_en        <= 1'b1;
                        row_in_en         <= cnt[IW-1:0];
                        row_ps_en         <= cnt[IW-1:0];
                        array_in_partials <= row_partial;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_row_feeder.sv
// Bench for systolic_array_row_feeder: transaction-level scoreboard plus directed timing checks.
module tb_systolic_array_row_feeder;

    localparam int N   = sys_arr_pkg::N;
    localparam int DW  = sys_arr_pkg::DW;
    localparam int GAP = 1;
    localparam int IW  = $clog2(N);
    localparam int RW  = 4 + 2 * IW + 2 * N * DW;
    localparam logic [N*DW-1:0] PS_ONE = {N{16'h3C00}};

    logic tb_clk = 1'b0;
    logic nRST;
    logic cmd_valid, cmd_ready, cmd_load_weights;
    logic row_valid, row_ready;
    logic [N*DW-1:0] row_data, row_partial;
    logic drained, fifo_has_space;
    logic weight_en, input_en, partial_en;
    logic [IW-1:0] row_in_en, row_ps_en;
    logic [N*DW-1:0] array_in, array_in_partials;
    logic busy, tile_done;

    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 tb_clk = ~tb_clk;

    systolic_array_row_feeder #(.N(N), .DW(DW), .GAP(GAP)) dut (
        .clk(tb_clk), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_weights(cmd_load_weights),
        .row_valid(row_valid), .row_ready(row_ready),
        .row_data(row_data), .row_partial(row_partial),
        .drained(drained), .fifo_has_space(fifo_has_space),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en),
        .array_in(array_in), .array_in_partials(array_in_partials),
        .busy(busy), .tile_done(tile_done)
    );

    task automatic check_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s @%0t: got timeout expected handshake", name, $time);
    endtask

    // ---------------- scoreboard / model ----------------
    logic [RW-1:0] exp_q[$];
    bit tile_q[$];
    int w_cnt = 0, i_cnt = 0;
    bit done_next = 1'b0;
    int cyc = 0;
    int drain_rise = 0;
    bit drained_prev = 1'b0;
    int ev_cyc[$], ev_idx[$], ev_ps[$], done_cyc[$];
    bit ev_w[$], ev_pen[$];
    logic [N*DW-1:0] ev_data[$], ev_part[$];

    always @(negedge tb_clk) begin : compare
        logic [RW-1:0] act;
        logic e_done, e_w, e_in;
        logic [IW-1:0] e_idx;
        logic [N*DW-1:0] e_a, e_p;
        cyc++;
        act = {tile_done, weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials};
        if (drained && !drained_prev) drain_rise = cyc;
        drained_prev = drained;
        if (weight_en || input_en) begin
            ev_cyc.push_back(cyc); ev_w.push_back(weight_en); ev_idx.push_back(int'(row_in_en));
            ev_ps.push_back(int'(row_ps_en)); ev_pen.push_back(partial_en);
            ev_data.push_back(array_in); ev_part.push_back(array_in_partials);
        end
        if (tile_done) done_cyc.push_back(cyc);
        if (!nRST) begin
            exp_q.delete(); tile_q.delete();
            w_cnt = 0; i_cnt = 0; done_next = 1'b0;
            check_vec("reset_outputs", act, '0);
            exp_q.push_back('0);
        end else begin
            if (exp_q.size() > 0) check_vec("array_side", act, exp_q.pop_front());
            e_done = done_next; done_next = 1'b0;
            e_w = 1'b0; e_in = 1'b0; e_idx = '0; e_a = '0; e_p = '0;
            if (cmd_valid && cmd_ready) tile_q.push_back(cmd_load_weights);
            if (row_valid && row_ready) begin
                if (tile_q.size() == 0) begin
                    fail("accept_without_cmd");
                end else if (tile_q[0] && w_cnt < N) begin
                    e_w = 1'b1; e_idx = IW'(N - 1 - w_cnt); e_a = row_data;
                    w_cnt++;
                end else begin
                    e_in = 1'b1; e_idx = IW'(i_cnt); e_a = row_data; e_p = row_partial;
                    i_cnt++;
                    if (i_cnt == N) begin
                        void'(tile_q.pop_front());
                        w_cnt = 0; i_cnt = 0; done_next = 1'b1;
                    end
                end
            end
            exp_q.push_back({e_done, e_w, e_in, e_in, e_idx, (e_in ? e_idx : IW'(0)), e_a, e_p});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        ev_cyc.delete(); ev_idx.delete(); ev_ps.delete(); done_cyc.delete();
        ev_w.delete(); ev_pen.delete(); ev_data.delete(); ev_part.delete();
    endtask

    task automatic send_cmd(input logic lw);
        int waited = 0;
        cmd_valid = 1'b1; cmd_load_weights = lw;
        @(negedge tb_clk);
        while (!cmd_ready && waited < 300) begin @(negedge tb_clk); waited++; end
        if (!cmd_ready) fail("cmd_timeout");
        @(posedge tb_clk); #1;
        cmd_valid = 1'b0; cmd_load_weights = 1'b0;
    endtask

    task automatic send_row(input logic [N*DW-1:0] d, input logic [N*DW-1:0] p);
        int waited = 0;
        row_valid = 1'b1; row_data = d; row_partial = p;
        @(negedge tb_clk);
        while (!row_ready && waited < 300) begin @(negedge tb_clk); waited++; end
        if (!row_ready) fail("row_timeout");
        @(posedge tb_clk); #1;
        row_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int waited = 0;
        while (done_cyc.size() < n && waited < 400) begin @(posedge tb_clk); waited++; end
        if (done_cyc.size() < n) fail("done_timeout");
        @(posedge tb_clk); #1;
    endtask

    // ---------------- stimulus ----------------
    logic [N*DW-1:0] wrow[4], irow[4], prow[4];
    int t1_idx[8] = '{3, 2, 1, 0, 0, 1, 2, 3};
    int t1_off[8] = '{0, 1, 2, 3, 5, 7, 9, 11};

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog @%0t: got no finish expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        wrow = '{64'h1000_1001_1002_1003, 64'h1100_1101_1102_1103, 64'h1200_1201_1202_1203, 64'h1300_1301_1302_1303};
        irow = '{64'hA000_A001_A002_A003, 64'hA100_A101_A102_A103, 64'hA200_A201_A202_A203, 64'hA300_A301_A302_A303};
        prow = '{64'h5000_5001_5002_5003, 64'h5100_5101_5102_5103, 64'h5200_5201_5202_5203, 64'h5300_5301_5302_5303};
        nRST = 1'b0; cmd_valid = 0; cmd_load_weights = 0; row_valid = 0;
        row_data = '0; row_partial = '0; drained = 0; fifo_has_space = 0;
        repeat (2) @(negedge tb_clk);
        check_int("rst_cmd_ready", int'(cmd_ready), 0);
        check_int("rst_busy", int'(busy), 0);
        @(posedge tb_clk); #3 nRST = 1'b1;
        @(posedge tb_clk); #1;
        check_int("cmd_ready_after_release", int'(cmd_ready), 1);

        // Weight tile with rows held valid back to back.
        drained = 1; fifo_has_space = 1; clear_logs();
        send_cmd(1'b1);
        for (int k = 0; k < 4; k++) send_row(wrow[k], prow[k]);
        for (int k = 0; k < 4; k++) send_row(irow[k], prow[k]);
        wait_done(1);
        check_int("t1_events", ev_cyc.size(), 8);
        for (int i = 0; i < 8; i++) if (i < ev_cyc.size()) begin
            check_int($sformatf("t1_idx%0d", i), ev_idx[i], t1_idx[i]);
            check_int($sformatf("t1_kind%0d", i), int'(ev_w[i]), (i < 4) ? 1 : 0);
            check_int($sformatf("t1_off%0d", i), ev_cyc[i] - ev_cyc[0], t1_off[i]);
            check_vec($sformatf("t1_data%0d", i), RW'(ev_data[i]), RW'((i < 4) ? wrow[i] : irow[i-4]));
        end
        if (done_cyc.size() > 0 && ev_cyc.size() > 0) check_int("t1_done_off", done_cyc[0] - ev_cyc[0], 12);

        // Drain wait, then output-space wait, with 1.0 partials.
        drained = 0; fifo_has_space = 0; clear_logs();
        send_cmd(1'b1);
        fork
            begin
                repeat (10) begin
                    @(negedge tb_clk);
                    check_int("drain_row_ready", int'(row_ready), 0);
                    check_int("drain_weight_en", int'(weight_en), 0);
                    check_int("drain_busy", int'(busy), 1);
                    check_int("drain_cmd_ready", int'(cmd_ready), 0);
                end
                @(posedge tb_clk); #1 drained = 1;
            end
            begin
                for (int k = 0; k < 4; k++) send_row(wrow[3-k], prow[k]);
                for (int k = 0; k < 4; k++) send_row(irow[k], PS_ONE);
            end
            begin
                int waited = 0;
                while (ev_cyc.size() < 4 && waited < 300) begin @(posedge tb_clk); waited++; end
                repeat (6) begin
                    @(negedge tb_clk);
                    check_int("space_input_en", int'(input_en), 0);
                    check_int("space_row_ready", int'(row_ready), 0);
                end
                @(posedge tb_clk); #1 fifo_has_space = 1;
            end
        join
        wait_done(1);
        check_int("t2_events", ev_cyc.size(), 8);
        if (ev_cyc.size() > 0) check_int("t2_first_weight_lat", ev_cyc[0] - drain_rise, 2);
        for (int i = 4; i < 8; i++) if (i < ev_cyc.size()) begin
            check_int($sformatf("t3_pen%0d", i), int'(ev_pen[i]), 1);
            check_int($sformatf("t3_ps_idx%0d", i), ev_ps[i], i - 4);
            check_vec($sformatf("t3_partial%0d", i), RW'(ev_part[i]), RW'(PS_ONE));
        end

        // row_valid withdrawn for 5 cycles between input rows 1 and 2.
        clear_logs();
        send_cmd(1'b0);
        send_row(irow[0], prow[0]);
        send_row(irow[1], prow[1]);
        repeat (5) @(posedge tb_clk);
        #1;
        send_row(irow[2], prow[2]);
        send_row(irow[3], prow[3]);
        wait_done(1);
        check_int("t4_events", ev_cyc.size(), 4);
        for (int i = 0; i < 4; i++) if (i < ev_cyc.size()) begin
            check_int($sformatf("t4_idx%0d", i), ev_idx[i], i);
            check_int($sformatf("t4_kind%0d", i), int'(ev_w[i]), 0);
        end
        if (ev_cyc.size() > 2) check_int("t4_stall_gap", ev_cyc[2] - ev_cyc[1], 6);

        // Asynchronous reset in the middle of the input phase.
        clear_logs();
        send_cmd(1'b0);
        send_row(irow[0], prow[0]);
        send_row(irow[1], prow[1]);
        #1 nRST = 1'b0;
        #1;
        check_int("arst_input_en", int'(input_en), 0);
        check_int("arst_partial_en", int'(partial_en), 0);
        check_int("arst_row_in_en", int'(row_in_en), 0);
        check_vec("arst_array_in", RW'(array_in), '0);
        check_int("arst_busy", int'(busy), 0);
        check_int("arst_cmd_ready", int'(cmd_ready), 0);
        repeat (2) @(posedge tb_clk);
        #3 nRST = 1'b1;
        @(posedge tb_clk); #1;
        check_int("post_rst_cmd_ready", int'(cmd_ready), 1);

        // Fresh tile, then a no-weight command held until the previous tile completes.
        drained = 0; clear_logs();
        send_cmd(1'b0);
        fork
            begin
                for (int k = 0; k < 4; k++) send_row(irow[k], prow[k]);
                for (int k = 0; k < 4; k++) send_row(wrow[k], prow[3-k]);
            end
            begin
                @(posedge tb_clk); #1;
                send_cmd(1'b0);
            end
        join
        wait_done(2);
        check_int("t6_events", ev_cyc.size(), 8);
        for (int i = 0; i < 8; i++) if (i < ev_cyc.size()) begin
            check_int($sformatf("t6_idx%0d", i), ev_idx[i], i % 4);
            check_int($sformatf("t6_kind%0d", i), int'(ev_w[i]), 0);
        end
        if (ev_cyc.size() > 4 && done_cyc.size() > 0) check_int("t6_b2b_lat", ev_cyc[4] - done_cyc[0], 3);

        repeat (3) @(posedge tb_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
